// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: WIDTH x DEPTH storage with one synchronous write port and
// one asynchronous read port. The contents are not reset.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address, 0..DEPTH-1
//   wdata  - write data
//   raddr  - read address, 0..DEPTH-1
//   rdata  - read data, a combinational view of mem[raddr]
module sync_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO. DEPTH does not have to be
// a power of two. The read side can run in one of two modes:
//   FWFT = 0 : registered read, data_out is loaded on the edge that pops
//   FWFT = 1 : the head word is visible on data_out while flag is high
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   flush              - synchronous clear of pointers, count and error flags
//   wr, data_in        - write request and write data
//   rd                 - read request (pop)
//   data_out           - read data
//   flag               - data available (not empty)
//   full, almost_full  - count == DEPTH, count >= AF_LEVEL
//   almost_empty       - count <= AE_LEVEL
//   count              - occupancy, 0..DEPTH
//   overflow/underflow - sticky flags: write while full / read while empty
module sync_fifo_param #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 10,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             flag,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  // Explicit wrap at DEPTH-1 so that non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             empty;
  logic             wr_acc, rd_acc;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign flag         = ~empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accepts use pre-edge status only: a read in this cycle never frees a
  // slot for a write in the same cycle.
  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;
  assign ram_we = wr_acc & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr & full)  overflow_d  = 1'b1;
      if (rd & empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; only meaningful while flag is high.
      assign data_out = ram_rdata;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc && !flush) dout_d = ram_rdata;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule
